// File: rtl/code_seq_arbiter.sv
// Round-robin arbiter that lends one code-sequence recognizer to two requesters,
// streams the granted requester's codes into it and reports a 2-bit verdict.
module code_seq_arbiter #(
    parameter int MAX_CODES    = 16,
    parameter int WATCH_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_code,
    output logic [1:0]  req_ready,
    output logic [1:0]  done,
    output logic [1:0]  result,
    output logic        fsm_reset,
    output logic [7:0]  fsm_entrada,
    input  logic [3:0]  fsm_saida
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [7:0]  MAX_C   = 8'(MAX_CODES);
    localparam logic [15:0] WATCH_C = 16'(WATCH_CYCLES);

    state_t      state_r;
    logic        grant_r;
    logic        prio_r;
    logic [7:0]  count_r;
    logic [15:0] wdog_r;
    logic [1:0]  result_r;
    logic [1:0]  done_r;

    logic        stream_ok_s;
    logic        accept_s;
    logic [16:0] wdog_next_s;
    logic        watch_hit_s;
    logic [1:0]  grant_onehot_s;

    // Terminal recognizer states map to the reported verdict.
    function automatic logic [1:0] verdict_of(input logic [3:0] saida);
        logic [1:0] v;
        case (saida)
            4'b1001: v = 2'b01;
            4'b1010: v = 2'b10;
            default: v = 2'b11;
        endcase
        return v;
    endfunction

    assign grant_onehot_s = grant_r ? 2'b10 : 2'b01;
    assign stream_ok_s    = (state_r == STREAM) && !fsm_saida[3] &&
                            (count_r < MAX_C) && (wdog_r < WATCH_C);
    assign accept_s       = stream_ok_s && req_valid[grant_r];
    assign wdog_next_s    = {1'b0, wdog_r} + 17'd1;
    assign watch_hit_s    = (wdog_next_s >= {1'b0, WATCH_C});

    assign fsm_reset = (state_r != STREAM);
    assign done      = done_r;
    assign result    = result_r;

    // Handshake and recognizer input follow the live grant; idle code 00 otherwise.
    always_comb begin
        req_ready   = 2'b00;
        fsm_entrada = 8'h00;
        if (stream_ok_s) begin
            req_ready = grant_onehot_s;
        end else begin
            req_ready = 2'b00;
        end
        if (accept_s) begin
            fsm_entrada = grant_r ? req_code[15:8] : req_code[7:0];
        end else begin
            fsm_entrada = 8'h00;
        end
    end

    // Arbitration / transaction state machine with registered verdict and done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            grant_r  <= 1'b0;
            prio_r   <= 1'b0;
            count_r  <= 8'd0;
            wdog_r   <= 16'd0;
            result_r <= 2'b00;
            done_r   <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 2'b00;
                    if (req_valid != 2'b00) begin
                        grant_r <= (req_valid == 2'b11) ? prio_r : req_valid[1];
                        count_r <= 8'd0;
                        wdog_r  <= 16'd0;
                        state_r <= STREAM;
                    end
                end
                STREAM: begin
                    done_r <= 2'b00;
                    wdog_r <= wdog_next_s[15:0];
                    if (accept_s) begin
                        count_r <= count_r + 8'd1;
                    end
                    // Terminal outranks both timeouts; the code-count check sees the
                    // cycle after the last accept so its result is already observable.
                    if (fsm_saida[3]) begin
                        result_r <= verdict_of(fsm_saida);
                        done_r   <= grant_onehot_s;
                        state_r  <= REPORT;
                    end else if ((count_r == MAX_C) && !accept_s) begin
                        result_r <= 2'b00;
                        done_r   <= grant_onehot_s;
                        state_r  <= REPORT;
                    end else if (watch_hit_s) begin
                        result_r <= 2'b00;
                        done_r   <= grant_onehot_s;
                        state_r  <= REPORT;
                    end
                end
                REPORT: begin
                    done_r  <= 2'b00;
                    prio_r  <= ~grant_r;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 2'b00;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_seq_arbiter.sv
// Randomized bench for code_seq_arbiter with a toy recognizer and a
// transaction-level reference model compared every cycle.
module tb_code_seq_arbiter;

    localparam int MAX_CODES    = 4;
    localparam int WATCH_CYCLES = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_code;
    logic [1:0]  req_ready;
    logic [1:0]  done;
    logic [1:0]  result;
    logic        fsm_reset;
    logic [7:0]  fsm_entrada;
    logic [3:0]  fsm_saida;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    code_seq_arbiter #(.MAX_CODES(MAX_CODES), .WATCH_CYCLES(WATCH_CYCLES)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_code(req_code),
        .req_ready(req_ready), .done(done), .result(result), .fsm_reset(fsm_reset),
        .fsm_entrada(fsm_entrada), .fsm_saida(fsm_saida)
    );

    // Toy recognizer: A0 84 89 -> 1001, AE 93 -> 1010, AE 84 -> 1000, AE 9A -> 1100.
    function automatic logic [3:0] rec_step(input logic [3:0] s, input logic [7:0] c);
        logic [3:0] n;
        n = s;
        case (s)
            4'd0: if (c == 8'hA0) n = 4'd1; else if (c == 8'hAE) n = 4'd3;
            4'd1: if (c == 8'h84) n = 4'd2; else if (c == 8'h89) n = 4'b1001;
            4'd2: if (c == 8'h89) n = 4'b1001;
            4'd3: if (c == 8'h93) n = 4'b1010; else if (c == 8'h84) n = 4'b1000;
                  else if (c == 8'h9A) n = 4'b1100;
            default: n = s;
        endcase
        return n;
    endfunction

    always_ff @(posedge clock or posedge fsm_reset) begin
        if (fsm_reset) fsm_saida <= 4'd0;
        else           fsm_saida <= rec_step(fsm_saida, fsm_entrada);
    end

    // Reference model state
    int         m_phase;   // 0 idle, 1 streaming, 2 reporting
    bit         m_owner, m_prio;
    int         m_acc, m_cyc;
    logic [1:0] m_result;
    logic [3:0] m_rec;

    logic [7:0] q0[$], q1[$];
    bit         en0 = 1'b1, en1 = 1'b1;
    logic [1:0] obs_done[$], obs_res[$];
    int         dut_acc, stream_cyc;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 1'b0; m_prio = 1'b0;
        m_acc = 0; m_cyc = 0; m_result = 2'b00; m_rec = 4'd0;
    endtask

    function automatic logic [1:0] verdict(input logic [3:0] s);
        if (s == 4'b1001) return 2'b01;
        if (s == 4'b1010) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [7:0] pick_code();
        logic [7:0] tbl [6];
        int k;
        tbl = '{8'hA0, 8'h84, 8'h89, 8'hAE, 8'h93, 8'h9A};
        k = $urandom_range(0, 6);
        if (k == 6) return 8'($urandom);
        return tbl[k];
    endfunction

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic tick();
        logic [1:0] v, er, ed;
        logic [7:0] c0, c1, cown, ee;
        logic       efr;
        bit         ok, acc;
        v[0] = (q0.size() > 0) && en0;
        v[1] = (q1.size() > 0) && en1;
        c0 = (q0.size() > 0) ? q0[0] : 8'($urandom);
        c1 = (q1.size() > 0) ? q1[0] : 8'($urandom);
        req_valid = v;
        req_code  = {c1, c0};
        #2;
        cown = m_owner ? c1 : c0;
        er = 2'b00; ed = 2'b00; efr = 1'b1; ee = 8'h00; ok = 1'b0; acc = 1'b0;
        if (m_phase == 1) begin
            ok  = !m_rec[3] && (m_acc < MAX_CODES) && (m_cyc < WATCH_CYCLES);
            acc = ok && v[m_owner];
            if (ok)  er = m_owner ? 2'b10 : 2'b01;
            if (acc) ee = cown;
            efr = 1'b0;
        end else if (m_phase == 2) begin
            ed = m_owner ? 2'b10 : 2'b01;
        end
        chk("req_ready",   {6'd0, req_ready}, {6'd0, er});
        chk("done",        {6'd0, done},      {6'd0, ed});
        chk("result",      {6'd0, result},    {6'd0, m_result});
        chk("fsm_reset",   {7'd0, fsm_reset}, {7'd0, efr});
        chk("fsm_entrada", fsm_entrada,       ee);
        if (done != 2'b00) begin
            obs_done.push_back(done);
            obs_res.push_back(result);
        end
        dut_acc += $countones(req_ready & req_valid);
        if (fsm_reset === 1'b0) stream_cyc++;
        case (m_phase)
            0: if (v != 2'b00) begin
                m_owner = (v == 2'b11) ? m_prio : v[1];
                m_acc = 0; m_cyc = 0; m_rec = 4'd0; m_phase = 1;
            end
            1: begin
                if (m_rec[3]) begin
                    m_result = verdict(m_rec); m_phase = 2;
                end else if (m_acc == MAX_CODES) begin
                    m_result = 2'b00; m_phase = 2;
                end else if (m_cyc + 1 >= WATCH_CYCLES) begin
                    m_result = 2'b00; m_phase = 2;
                end
                if (acc) begin
                    m_rec = rec_step(m_rec, cown);
                    m_acc++;
                    if (m_owner) q1.delete(0); else q0.delete(0);
                end
                m_cyc++;
            end
            default: begin
                m_prio = !m_owner; m_phase = 0; m_rec = 4'd0;
            end
        endcase
        @(posedge clock);
        #1;
    endtask

    task automatic run_until_done(input int n, input int budget, input string name);
        int target, k;
        target = obs_done.size() + n;
        k = 0;
        while (obs_done.size() < target && k < budget) begin
            tick();
            k++;
        end
        tests++;
        if (obs_done.size() < target) begin
            fails++;
            $display("FAIL %s: timeout, saw %0d done pulses, expected %0d", name, obs_done.size(), target);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        req_code = 16'h0000;
        q0.delete(); q1.delete();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_obs();
        obs_done.delete(); obs_res.delete();
        dut_acc = 0; stream_cyc = 0;
    endtask

    initial begin
        int k;
        reset = 1'b1;
        req_valid = 2'b00;
        req_code = 16'h0000;
        model_reset();
        do_reset();
        chk("rst_ready",     {6'd0, req_ready}, 8'h00);
        chk("rst_done",      {6'd0, done},      8'h00);
        chk("rst_result",    {6'd0, result},    8'h00);
        chk("rst_fsm_reset", {7'd0, fsm_reset}, 8'h01);

        // Req0 streams A0 84 89.
        clear_obs();
        q0 = '{8'hA0, 8'h84, 8'h89};
        run_until_done(1, 40, "t1");
        chk("t1_done",    {6'd0, obs_done[0]}, 8'h01);
        chk("t1_result",  {6'd0, obs_res[0]},  8'h01);
        chk("t1_accepts", 8'(dut_acc),         8'd3);

        // Both valid from reset: req0 first, then req1.
        do_reset();
        clear_obs();
        q0 = '{8'hA0, 8'h89};
        q1 = '{8'hAE, 8'h93};
        run_until_done(2, 60, "t2");
        chk("t2_done0",   {6'd0, obs_done[0]}, 8'h01);
        chk("t2_result0", {6'd0, obs_res[0]},  8'h01);
        chk("t2_done1",   {6'd0, obs_done[1]}, 8'h02);
        chk("t2_result1", {6'd0, obs_res[1]},  8'h02);

        // Req1: AE 84 terminates on 1000, 9A never accepted.
        clear_obs();
        q1 = '{8'hAE, 8'h84, 8'h9A};
        run_until_done(1, 40, "t3");
        chk("t3_done",    {6'd0, obs_done[0]}, 8'h02);
        chk("t3_result",  {6'd0, obs_res[0]},  8'h03);
        chk("t3_accepts", 8'(dut_acc),         8'd2);
        q1.delete();

        // Code-count timeout after MAX_CODES accepts.
        clear_obs();
        repeat (8) q0.push_back(8'hA0);
        run_until_done(1, 40, "t4");
        chk("t4_done",    {6'd0, obs_done[0]}, 8'h01);
        chk("t4_result",  {6'd0, obs_res[0]},  8'h00);
        chk("t4_accepts", 8'(dut_acc),         8'd4);
        q0.delete();

        // Watchdog timeout: one code then valid drops.
        clear_obs();
        q0 = '{8'hA0};
        run_until_done(1, 40, "t5");
        chk("t5_done",         {6'd0, obs_done[0]}, 8'h01);
        chk("t5_result",       {6'd0, obs_res[0]},  8'h00);
        chk("t5_stream_cycles", 8'(stream_cyc),     8'd8);

        // Reset pulsed while streaming with saida = 0010.
        do_reset();
        q0 = '{8'hA0, 8'h84, 8'h89};
        q1 = '{8'hAE, 8'h93};
        k = 0;
        while (fsm_saida !== 4'b0010 && k < 20) begin
            tick();
            k++;
        end
        chk("t6_reached_0010", {4'd0, fsm_saida}, 8'h02);
        chk("t6_streaming",    {7'd0, fsm_reset}, 8'h00);
        reset = 1'b1;
        #1;
        chk("t6_ready",     {6'd0, req_ready}, 8'h00);
        chk("t6_done",      {6'd0, done},      8'h00);
        chk("t6_fsm_reset", {7'd0, fsm_reset}, 8'h01);
        chk("t6_entrada",   fsm_entrada,       8'h00);
        model_reset();
        q0.delete(); q1.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_obs();
        q0 = '{8'hA0, 8'h89};
        q1 = '{8'hAE, 8'h93};
        run_until_done(1, 40, "t6_after");
        chk("t6_first_grant", {6'd0, obs_done[0]}, 8'h01);

        // Randomized traffic with dropouts and occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 5) == 0)
                repeat ($urandom_range(1, 6)) q0.push_back(pick_code());
            if (q1.size() == 0 && $urandom_range(0, 5) == 0)
                repeat ($urandom_range(1, 6)) q1.push_back(pick_code());
            en0 = ($urandom_range(0, 7) != 0);
            en1 = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                chk("rnd_rst_ready",     {6'd0, req_ready}, 8'h00);
                chk("rnd_rst_done",      {6'd0, done},      8'h00);
                chk("rnd_rst_fsm_reset", {7'd0, fsm_reset}, 8'h01);
                model_reset();
                q0.delete(); q1.delete();
                @(posedge clock);
                #1;
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
